// File: rtl/watchdog_recovery_if.sv
// Recovery-sequencer bus: the watchdog-facing inputs (bark, clear_fault)
// and the recovery outputs (sys_reset_out, fault, retry_count).
// The master side is the watchdog/supervisor; the slave side is the sequencer.
interface watchdog_recovery_if #(
  parameter int MAX_RETRIES = 3
) ();
  localparam int RW = $clog2(MAX_RETRIES + 1);

  logic          bark;
  logic          clear_fault;
  logic          sys_reset_out;
  logic          fault;
  logic [RW-1:0] retry_count;

  modport master (
    output bark,
    output clear_fault,
    input  sys_reset_out,
    input  fault,
    input  retry_count
  );

  modport slave (
    input  bark,
    input  clear_fault,
    output sys_reset_out,
    output fault,
    output retry_count
  );
endinterface

// File: rtl/watchdog_recovery.sv
// Recovery sequencer downstream of the watchdog.
// Each bark produces a PULSE_TICKS-wide system reset pulse and then a hold-off
// window. After MAX_RETRIES attempts without an intervening healthy period,
// the next bark latches a fault that holds the system in reset until it is
// cleared. A run of bark-free idle cycles returns the retry budget.

// Invariant checker for the sequencer outputs.
module watchdog_recovery_chk #(
  parameter int MAX_RETRIES = 3,
  parameter int RW          = 2
) (
  input logic          clk,
  input logic          reset,
  input logic          sys_reset_out,
  input logic          fault,
  input logic [RW-1:0] retry_count
);
  // A latched fault always keeps the protected logic in reset.
  a_fault_holds_reset: assert property (
    @(posedge clk) disable iff (reset) fault |-> sys_reset_out
  );

  // The retry count saturates at the budget and never wraps.
  a_retry_bounded: assert property (
    @(posedge clk) disable iff (reset) retry_count <= RW'(MAX_RETRIES)
  );
endmodule

module watchdog_recovery #(
  parameter int PULSE_TICKS   = 4,
  parameter int HOLDOFF_TICKS = 8,
  parameter int MAX_RETRIES   = 3,
  parameter int HEALTHY_TICKS = 16
) (
  input logic               clk,
  input logic               reset,
  watchdog_recovery_if.slave bus
);
  localparam int RW       = $clog2(MAX_RETRIES + 1);
  localparam int TICK_MAX = (PULSE_TICKS > HOLDOFF_TICKS) ? PULSE_TICKS : HOLDOFF_TICKS;
  localparam int TW       = $clog2(TICK_MAX + 1);
  localparam int HW       = $clog2(HEALTHY_TICKS + 1);

  // Terminal counts. The hold-off window includes the edge that leaves PULSE,
  // so HOLDOFF starts with one tick already consumed; the healthy window
  // likewise includes the edge that enters IDLE.
  localparam logic [TW-1:0] PULSE_LAST   = TW'(PULSE_TICKS - 1);
  localparam logic [TW-1:0] HOLD_LAST    = TW'(HOLDOFF_TICKS - 1);
  localparam logic [HW-1:0] HEALTHY_LAST = HW'(HEALTHY_TICKS - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t        state_r;
  logic [TW-1:0] tick_r;
  logic [HW-1:0] healthy_r;
  logic [RW-1:0] retry_count_r;
  logic          sys_reset_out_r;
  logic          fault_r;
  logic [HW-1:0] healthy_inc_s;

  assign healthy_inc_s = healthy_r + HW'(1);

  // Recovery FSM: state, counters and all outputs updated on one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      tick_r          <= TW'(0);
      healthy_r       <= HW'(0);
      retry_count_r   <= RW'(0);
      sys_reset_out_r <= 1'b0;
      fault_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.bark) begin
            // Bark takes priority over a healthy-window expiry on the same edge.
            healthy_r <= HW'(0);
            if (retry_count_r < RETRY_LIMIT) begin
              state_r         <= PULSE;
              retry_count_r   <= retry_count_r + RW'(1);
              tick_r          <= TW'(0);
              sys_reset_out_r <= 1'b1;
              fault_r         <= 1'b0;
            end else begin
              state_r         <= FAULT;
              sys_reset_out_r <= 1'b1;
              fault_r         <= 1'b1;
            end
          end else if (healthy_inc_s >= HEALTHY_LAST) begin
            healthy_r     <= HW'(0);
            retry_count_r <= RW'(0);
          end else begin
            healthy_r <= healthy_inc_s;
          end
        end

        PULSE: begin
          // Bark is not sampled while the reset pulse is being driven.
          if (tick_r >= PULSE_LAST) begin
            sys_reset_out_r <= 1'b0;
            if (HOLDOFF_TICKS == 1) begin
              // The single hold-off tick is the PULSE exit edge itself.
              state_r   <= IDLE;
              tick_r    <= TW'(0);
              healthy_r <= HW'(0);
            end else begin
              state_r <= HOLDOFF;
              tick_r  <= TW'(1);
            end
          end else begin
            tick_r <= tick_r + TW'(1);
          end
        end

        HOLDOFF: begin
          // Protected logic is coming out of reset; bark is ignored here.
          if (tick_r >= HOLD_LAST) begin
            state_r   <= IDLE;
            tick_r    <= TW'(0);
            healthy_r <= HW'(0);
          end else begin
            tick_r <= tick_r + TW'(1);
          end
        end

        FAULT: begin
          // Only an explicit clear leaves FAULT; bark is ignored.
          if (bus.clear_fault) begin
            state_r         <= IDLE;
            retry_count_r   <= RW'(0);
            sys_reset_out_r <= 1'b0;
            fault_r         <= 1'b0;
            tick_r          <= TW'(0);
            healthy_r       <= HW'(0);
          end else begin
            sys_reset_out_r <= 1'b1;
            fault_r         <= 1'b1;
          end
        end

        default: begin
          state_r         <= IDLE;
          tick_r          <= TW'(0);
          healthy_r       <= HW'(0);
          sys_reset_out_r <= 1'b0;
          fault_r         <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sys_reset_out = sys_reset_out_r;
  assign bus.fault         = fault_r;
  assign bus.retry_count   = retry_count_r;

  watchdog_recovery_chk #(
    .MAX_RETRIES (MAX_RETRIES),
    .RW          (RW)
  ) u_chk (
    .clk           (clk),
    .reset         (reset),
    .sys_reset_out (sys_reset_out_r),
    .fault         (fault_r),
    .retry_count   (retry_count_r)
  );
endmodule

// File: tb/tb_watchdog_recovery.sv
// Bench for watchdog_recovery with parameters 4/8/3/16. Each cycle the
// expected outputs for that edge are queued with the stimulus and popped
// when the registered outputs are sampled just after the edge.
module tb_watchdog_recovery;
  localparam int PT = 4;
  localparam int HT = 8;
  localparam int MR = 3;
  localparam int HK = 16;

  typedef struct {
    string      tag;
    logic       s;
    logic       f;
    logic [1:0] r;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb_q[$];
  int   n_checks;
  int   n_errors;

  watchdog_recovery_if #(.MAX_RETRIES(MR)) wif ();

  watchdog_recovery #(
    .PULSE_TICKS   (PT),
    .HOLDOFF_TICKS (HT),
    .MAX_RETRIES   (MR),
    .HEALTHY_TICKS (HK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (wif)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue the outputs expected after the edge,
  // then pop and compare against the sampled outputs.
  task automatic cyc(input logic b, input logic c, input logic r,
                     input logic es, input logic ef, input logic [1:0] er, input string tag);
    exp_t e;
    reset           = r;
    wif.bark        = b;
    wif.clear_fault = c;
    e.tag = tag;
    e.s   = es;
    e.f   = ef;
    e.r   = er;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_val({tag, "_sb"}, 8'(sb_q.size()), 8'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val({e.tag, "_sys"},   {7'd0, wif.sys_reset_out}, {7'd0, e.s});
      check_val({e.tag, "_fault"}, {7'd0, wif.fault},         {7'd0, e.f});
      check_val({e.tag, "_retry"}, {6'd0, wif.retry_count},   {6'd0, e.r});
    end
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, "reset");
  endtask

  // One recovery attempt: bark sampled in IDLE, then PT-1 further pulse
  // cycles and HT hold-off cycles during which bark is ignored.
  task automatic run_pulse(input logic pulse_bark, input logic hold_bark, input logic [1:0] r_exp);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, r_exp, $sformatf("pulse_start_r%0d", r_exp));
    for (int i = 1; i < PT; i++)
      cyc(pulse_bark, 1'b0, 1'b0, 1'b1, 1'b0, r_exp, $sformatf("pulse_%0d", i));
    for (int i = 0; i < HT; i++)
      cyc(hold_bark, 1'b0, 1'b0, 1'b0, 1'b0, r_exp, $sformatf("holdoff_%0d", i));
  endtask

  initial begin
    clk             = 1'b0;
    reset           = 1'b1;
    wif.bark        = 1'b0;
    wif.clear_fault = 1'b0;
    n_checks        = 0;
    n_errors        = 0;

    // Reset overrides bark and clear_fault; bark sampled on first free edge.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, "rst_hold");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, "rst_first_bark");
    for (int i = 1; i < PT; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, "rst_pulse");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, "rst_pulse_end");
    do_reset();

    // Single bark; bark during the hold-off window is ignored, and the
    // first bark after the window is taken exactly at k+PT+HT.
    for (int i = 0; i < 9; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "idle_clear_noeffect");
    run_pulse(1'b0, 1'b1, 2'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, "hold_exit_bark");
    do_reset();

    // Bark held: three attempts 12 cycles apart, then FAULT.
    for (int p = 1; p <= MR; p++)
      run_pulse(1'b1, 1'b1, 2'(p));
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, "fault_entry");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, "fault_hold");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "fault_clear");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, "post_clear_pulse");
    do_reset();

    // Reset while in FAULT drops both outputs on that edge.
    for (int p = 1; p <= MR; p++)
      run_pulse(1'b1, 1'b1, 2'(p));
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, "fault_entry2");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, "fault_reset");

    // Healthy window: retry_count clears HK-1 edges after IDLE entry.
    run_pulse(1'b0, 1'b0, 2'd1);
    for (int i = 1; i < HK - 1; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, "healthy_wait");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "healthy_clear");

    // Bark on the clearing edge wins: count goes to 2 instead of 0.
    run_pulse(1'b0, 1'b0, 2'd1);
    for (int i = 1; i < HK - 1; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, "healthy_wait2");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, "bark_on_clear_edge");
    do_reset();

    // Reset in the second pulse cycle, then a fresh full attempt.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, "t6_bark");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, "t6_reset");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "t6_idle");
    run_pulse(1'b0, 1'b0, 2'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, "t6_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
